// File: rtl/debounce_sync_pkg.sv
// rtl/debounce_sync_pkg.sv - shared defaults and counter sizing helper for debounce_sync
package debounce_sync_pkg;

   localparam int DEFAULT_SYNC_STAGES = 2;
   localparam int DEFAULT_DB_CYCLES   = 4;

   // ceil(log2(n)) with a floor of 1 bit so a DB_CYCLES=1 counter still has a legal width
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one channel: synchroniser chain, stability counter, edge pulses
module debounce_chan
   import debounce_sync_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DB_CYCLES   = DEFAULT_DB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int             CW      = clog2_min1(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s;
   logic                   clean_q, clean_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // shift the raw level into the synchroniser; s is the metastability-safe sample
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // count consecutive disagreeing samples; accept on the DB_CYCLES-th and fire a pulse
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         clean_d = s;
         rise_d  = s;
         fall_d  = ~s;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // all channel state clears asynchronously so no pulse can come out of reset itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean_o = clean_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - N independent synchronise-and-debounce channels feeding the gate stage
module debounce_sync
   import debounce_sync_pkg::*;
#(
   parameter int N           = 3,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DB_CYCLES   = DEFAULT_DB_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] raw_in,
   output logic [N-1:0] clean_out,
   output logic [N-1:0] rise_pulse,
   output logic [N-1:0] fall_pulse
);

   // one self-contained channel per input bit; no state is shared between channels
   for (genvar g = 0; g < N; g++) begin : g_chan
      debounce_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (raw_in[g]),
         .clean_o (clean_out[g]),
         .rise_o  (rise_pulse[g]),
         .fall_o  (fall_pulse[g])
      );
   end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized and directed self-checking bench for debounce_sync
module tb_debounce_sync;

   localparam int N  = 3;
   localparam int S  = 2;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] raw_in = '0;
   logic [N-1:0] clean_out, rise_pulse, fall_pulse;

   int checks = 0;
   int errors = 0;

   // reference: raw delayed S samples, accepted when the last DB samples all disagree
   bit sd [N][S];
   bit wv [N][DB];
   int wn [N];
   bit m_clean [N];
   bit m_rise [N];
   bit m_fall [N];

   int rise_cnt [N];
   int fall_cnt [N];
   int edge_no;
   int rise_edge [N];

   debounce_sync #(.N(N), .SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < S; j++) sd[i][j] = 1'b0;
         wn[i] = 0;
         m_clean[i] = 1'b0;
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit smp;
      bit acc;
      for (int i = 0; i < N; i++) begin
         smp = sd[i][S-1];
         for (int j = S-1; j > 0; j--) sd[i][j] = sd[i][j-1];
         sd[i][0] = raw_in[i];
         if (wn[i] < DB) begin
            wv[i][wn[i]] = smp;
            wn[i]++;
         end else begin
            for (int j = 0; j < DB-1; j++) wv[i][j] = wv[i][j+1];
            wv[i][DB-1] = smp;
         end
         acc = (wn[i] == DB);
         for (int j = 0; j < DB; j++) if (wv[i][j] == m_clean[i]) acc = 1'b0;
         m_rise[i] = acc && smp;
         m_fall[i] = acc && !smp;
         if (acc) begin
            m_clean[i] = smp;
            wn[i] = 0;
         end
      end
   endtask

   function automatic logic [N-1:0] pack(input bit v [N]);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      edge_no++;
      @(negedge clk);
      check("clean", clean_out, pack(m_clean));
      check("rise", rise_pulse, pack(m_rise));
      check("fall", fall_pulse, pack(m_fall));
      check("excl", rise_pulse & fall_pulse, '0);
      for (int i = 0; i < N; i++) begin
         if (rise_pulse[i]) begin
            rise_cnt[i]++;
            rise_edge[i] = edge_no;
         end
         if (fall_pulse[i]) fall_cnt[i]++;
      end
   endtask

   task automatic clear_counts();
      edge_no = 0;
      for (int i = 0; i < N; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
         rise_edge[i] = -1;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // raw held at 111 across release: clean is 0 through edge 5, 111 after edge 6, single pulse
   task automatic latency_check();
      clear_counts();
      for (int e = 1; e <= 8; e++) begin
         tick();
         check("lat_clean", clean_out, (e >= 6) ? 32'h7 : 32'h0);
         check("lat_rise", rise_pulse, (e == 6) ? 32'h7 : 32'h0);
      end
   endtask

   initial begin
      model_reset();
      clear_counts();

      // reset check
      raw_in = 3'b111;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_clean", clean_out, 0);
      check("rst_rise", rise_pulse, 0);
      check("rst_fall", fall_pulse, 0);
      rst_n = 1'b1;
      latency_check();

      // glitch rejection on channel 0
      raw_in = 3'b000;
      run(12);
      clear_counts();
      raw_in[0] = 1'b1;
      run(3);
      raw_in[0] = 1'b0;
      run(10);
      check("glitch_rise0", rise_cnt[0], 0);
      check("glitch_clean0", clean_out[0], 0);

      // boundary run on channel 1: exactly DB cycles high
      clear_counts();
      raw_in[1] = 1'b1;
      run(4);
      raw_in[1] = 1'b0;
      run(4);
      check("bnd_rise_edge", rise_edge[1], 6);
      run(8);
      check("bnd_rise_cnt", rise_cnt[1], 1);
      check("bnd_fall_cnt", fall_cnt[1], 1);

      // interrupted count on channel 2: high 3, low 1, high 10
      clear_counts();
      raw_in[2] = 1'b1;
      run(3);
      raw_in[2] = 1'b0;
      run(1);
      raw_in[2] = 1'b1;
      run(10);
      check("intr_rise_edge", rise_edge[2], 10);
      check("intr_rise_cnt", rise_cnt[2], 1);

      // independent channels: simultaneous opposite transitions
      raw_in = 3'b011;
      run(12);
      clear_counts();
      raw_in = 3'b100;
      run(10);
      check("ind_rise", {rise_cnt[2] == 1, rise_cnt[1] == 0, rise_cnt[0] == 0}, 3'b111);
      check("ind_fall", {fall_cnt[2] == 0, fall_cnt[1] == 1, fall_cnt[0] == 1}, 3'b111);

      // mid-count reset with clean high and cnt at 2
      raw_in = 3'b111;
      run(12);
      raw_in = 3'b000;
      run(4);
      #2 rst_n = 1'b0;
      #1;
      check("mid_clean", clean_out, 0);
      check("mid_rise", rise_pulse, 0);
      check("mid_fall", fall_pulse, 0);
      model_reset();
      raw_in = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      latency_check();

      // randomized hold lengths per channel with occasional asynchronous resets
      begin
         int hold [N];
         for (int i = 0; i < N; i++) hold[i] = 0;
         for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
               if (hold[i] == 0) begin
                  raw_in[i] = $urandom_range(0, 1);
                  hold[i] = $urandom_range(1, 8);
               end
               hold[i]--;
            end
            tick();
            if ($urandom_range(0, 249) == 0) begin
               #2 rst_n = 1'b0;
               #1;
               check("rnd_rst", {clean_out, rise_pulse, fall_pulse}, 0);
               model_reset();
               @(negedge clk);
               rst_n = 1'b1;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
